framed_shift_register: RTL
==========================

# framed_shift_register

Parametrised serial/parallel shift register for the codebase's key and data paths. It supports the following:
- serial shifting in either direction;
- rotate mode;
- synchronous parallel load;
- a serial output tap;
- a frame counter that pulses `frame_done` once every SIZE shifts.

It replaces fixed-width 256-bit SIPO instances and also serves as a PISO by loading in parallel and shifting out through `s_out`.

## Interface

Parameters:
- `SIZE`, default 256: register width in bits. Must be ≥ 2; any value is legal (no power-of-two requirement).
- `RESET_VALUE`, default 256'h477887da7844557a78545e784ff785487e1578785477887da78445aaaaaaaaaa: value loaded into `p_out` on reset. Width is SIZE.
- Derived `CW` = max(1, $clog2(SIZE)): width of `count`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `load`, in, 1: synchronous parallel load strobe.
- `p_in`, in, SIZE: parallel load data.
- `shift`, in, 1: shift enable, one bit per cycle.
- `dir`, in, 1: 0 = shift left (toward MSB), 1 = shift right (toward LSB).
- `rotate`, in, 1: 1 = the bit shifted out re-enters at the opposite end, and `s_in` is ignored.
- `s_in`, in, 1: serial input.
- `s_out`, out, 1: next bit to leave the register. Combinational from `p_out` and `dir`.
- `p_out`, out, SIZE: register contents (registered).
- `count`, out, CW: number of shifts performed in the current frame (registered).
- `frame_done`, out, 1: one-cycle pulse marking frame completion (registered).

## Operation

- **Reset** (asynchronous, any time, including mid-frame): `p_out` = RESET_VALUE, `count` = 0, `frame_done` = 0. State is held while `reset` = 1.
- **Priority per edge:** `load` > `shift` > hold.
- **Load** (`load` = 1):
  - `p_out` ← `p_in`, `count` ← 0, `frame_done` ← 0.
  - A simultaneous `shift` is ignored.
- **Shift left** (`shift` = 1, `dir` = 0): `p_out` ← {`p_out`[SIZE-2:0], `b`}.
  - `b` = `p_out`[SIZE-1] if `rotate`, else `s_in`.
- **Shift right** (`shift` = 1, `dir` = 1): `p_out` ← {`b`, `p_out`[SIZE-1:1]}.
  - `b` = `p_out`[0] if `rotate`, else `s_in`.
- **`s_out`** = `p_out`[SIZE-1] when `dir` = 0, `p_out`[0] when `dir` = 1. It always equals the bit the next shift discards (or rotates).
- **Frame counter** (advances on every accepted shift):
  - If `count` = SIZE-1: `count` ← 0 and `frame_done` ← 1.
  - Otherwise: `count` ← `count` + 1 and `frame_done` ← 0.
- **`frame_done`** is 0 on every edge that does not complete a frame: hold, load, or a non-final shift.
- **Changing `dir` or `rotate` mid-frame** is legal. The counter is unaffected and keeps counting shifts, not direction.
- **Hold** (`load` = 0, `shift` = 0): all registers keep their values. `frame_done` returns to 0.

## Timing

- **Latency:**
  - `p_out` and `count` reflect a load or shift one edge after the strobe is sampled.
  - `s_out` follows `p_out` combinationally, and follows `dir` with zero cycles of delay.
- **`frame_done`** is high for exactly the one cycle after the edge that performs the SIZE-th shift of a frame.
  - With continuous shifting from `count` = 0, it pulses on cycles SIZE, 2·SIZE, … after shifting starts.
  - Back-to-back frames give pulses separated by exactly SIZE cycles, with no gap cycle between frames.
- **Reset deassertion:** the first edge with `reset` = 0 may perform a load or shift.
- **Throughput:** one bit per clock.

## Test plan

All scenarios use SIZE = 8 and RESET_VALUE = 8'hA5 unless stated otherwise.

1. **Reset / default:**
   - Assert `reset` asynchronously mid-cycle → `p_out` = 8'hA5, `count` = 0, `frame_done` = 0 immediately, without a clock edge.
   - Default parameters → `p_out` = the 256-bit RESET_VALUE constant.
2. **SIPO left:** from reset, shift 8 cycles with `dir` = 0, `rotate` = 0, `s_in` = 1,0,1,1,0,0,1,0 → `p_out` = 8'hB2.
   - `count` steps 1..7 then 0.
   - `frame_done` = 1 only in the cycle after the 8th shift.
3. **PISO right:** load `p_in` = 8'h3C, then shift 8 with `dir` = 1, `s_in` = 0 → `s_out` sequence before each edge = 0,0,1,1,1,1,0,0.
   - Final `p_out` = 8'h00.
   - One `frame_done` pulse.
4. **Rotate:**
   - Load 8'h81, shift left 1 with `rotate` = 1 → 8'h03.
   - Then shift right 3 → 8'h60.
   - After 8 total rotations of a fresh 8'h81, `p_out` = 8'h81 again and `frame_done` pulses.
5. **Priority and abort:**
   - `load` = 1 and `shift` = 1 on the same edge with `p_in` = 8'h5A → `p_out` = 8'h5A, `count` = 0.
   - Load at `count` = 5 mid-frame → `count` = 0, and no `frame_done` until 8 further shifts.
   - Assert reset at `count` = 7 → no `frame_done` pulse.
6. **Continuous frames and non-power-of-two width:**
   - 24 back-to-back shifts → `frame_done` pulses exactly at cycles 8, 16, 24.
   - Repeat with SIZE = 5 → `count` wraps 4→0 and `frame_done` fires every 5 shifts.

Source files
------------

// File: rtl/framed_shift_register.sv
// Bidirectional serial/parallel shift register with rotate and a frame counter pulsing every SIZE shifts.
// p_out/count/frame_done update one edge after load/shift; s_out is combinational; no backpressure, one bit per clock.
module framed_shift_register #(
  parameter int SIZE = 256,
  parameter logic [SIZE-1:0] RESET_VALUE =
    256'h477887da7844557a78545e784ff785487e1578785477887da78445aaaaaaaaaa,
  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [SIZE-1:0] p_in,
  input  logic            shift,
  input  logic            dir,
  input  logic            rotate,
  input  logic            s_in,
  output logic            s_out,
  output logic [SIZE-1:0] p_out,
  output logic [CW-1:0]   count,
  output logic            frame_done
);

  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  logic [SIZE-1:0] p_out_q, p_out_d;
  logic [CW-1:0]   count_q, count_d;
  logic            frame_done_q, frame_done_d;
  logic            fill_bit;

  // The bit entering the register is the one leaving the far end when rotating.
  assign fill_bit = rotate ? (dir ? p_out_q[0] : p_out_q[SIZE-1]) : s_in;

  always_comb begin
    p_out_d      = p_out_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    if (load) begin
      p_out_d = p_in;
      count_d = '0;
    end else if (shift) begin
      if (dir) p_out_d = {fill_bit, p_out_q[SIZE-1:1]};
      else     p_out_d = {p_out_q[SIZE-2:0], fill_bit};
      if (count_q == LAST) begin
        count_d      = '0;
        frame_done_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_out_q      <= RESET_VALUE;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      p_out_q      <= p_out_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_out      = dir ? p_out_q[0] : p_out_q[SIZE-1];
  assign p_out      = p_out_q;
  assign count      = count_q;
  assign frame_done = frame_done_q;

endmodule
